// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-client arbiter/sequencer in front of a single-port RAM (registered
//   address, combinational q from the registered address). Each client issues
//   single-beat read or write commands over req/gnt; commands are serialised
//   onto the one RAM port.
//
//   Ports
//     clk, rst_n                 clock, async active-low reset
//     req_x, we_x, addr_x,
//     wdata_x   (x = a, b)       client command
//     gnt_x                      one-cycle grant pulse (registered)
//     rvalid_x, rdata_x          one-cycle read-valid pulse, registered data
//     ram_en, ram_addr, ram_data RAM write enable / address / write data
//     ram_q                      RAM read data
//     busy                       high whenever the FSM is not IDLE
//
//   Build option
//     RAM_ARB_RR_EN  defined   -> round-robin on ties (last grant = B after reset)
//                    undefined -> fixed priority, A over B
module ram_port_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD_ADDR = 2'd2;
  localparam logic [1:0] RD_DATA = 2'd3;

  logic [1:0]    state;
  logic          cmd_sel;   // 0 = client A owns the command in flight, 1 = B
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          take;      // a command is accepted at this edge
  logic          pick_b;    // arbitration result, valid when take = 1
  logic          win_we;

  assign take = (state == IDLE) && (req_a || req_b);

`ifdef RAM_ARB_RR_EN
  logic last_b;  // 1 = B was granted most recently

  // On a tie the client not granted last wins.
  assign pick_b = req_b && (!req_a || !last_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_b <= 1'b1;
    else if (take) last_b <= pick_b;
  end
`else
  assign pick_b = req_b && !req_a;
`endif

  assign win_we = pick_b ? we_b : we_a;

  // The command direction is carried by the next state, so no separate
  // we register is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_sel   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      gnt_a    <= take && !pick_b;
      gnt_b    <= take && pick_b;
      rvalid_a <= (state == RD_DATA) && !cmd_sel;
      rvalid_b <= (state == RD_DATA) && cmd_sel;
      if (state == RD_DATA) begin
        if (cmd_sel) rdata_b <= ram_q;
        else         rdata_a <= ram_q;
      end
      case (state)
        IDLE: begin
          if (take) begin
            cmd_sel   <= pick_b;
            cmd_addr  <= pick_b ? addr_b  : addr_a;
            cmd_wdata <= pick_b ? wdata_b : wdata_a;
            state     <= win_we ? WR : RD_ADDR;
          end
        end
        WR:      state <= IDLE;
        RD_ADDR: state <= RD_DATA;
        RD_DATA: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational from state so an async reset drops the write enable at once.
  assign ram_en   = (state == WR);
  assign ram_addr = cmd_addr;
  assign ram_data = cmd_wdata;
  assign busy     = (state != IDLE);

endmodule
